nvram_upload_reader: RTL
========================

Name: nvram_upload_reader

Overview:
- Responder on the data_io upload (host read-back) path: services host byte reads by fetching from a core-side synchronous RAM (hiscore/NVRAM) and returning data on ioctl_din.
- Counterpart of the download writer path: data_io drives the address and read strobe, and this block supplies the data.
- Pauses the core during the upload so RAM contents are stable.
- Sits in the arcade top level between data_io and the core's dual-port hiscore RAM B-port, in the clk_sys domain.

Parameters:
- AW, 10, RAM address width in bits.
- SIZE, 1024, number of valid RAM bytes; must satisfy 1 <= SIZE <= 2^AW.
- RAM_LAT, 1, RAM read latency in cycles from ram_rd to valid ram_q; legal range 1..3.
- PAUSE_TIMEOUT, 255, maximum cycles to wait for core_pause_ack.
- FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active (level, from data_io).
- ioctl_rd  in  1  single-cycle read strobe from data_io.
- ioctl_addr  in  25  byte address; sampled in the cycle ioctl_rd is high.
- ioctl_din  out  8  returned data byte.
- ioctl_din_valid  out  1  high while ioctl_din holds data for the latest accepted read.
- core_pause  out  1  request that the core freeze its RAM writes.
- core_pause_ack  in  1  core has frozen.
- ram_addr  out  AW  RAM B-port address.
- ram_rd  out  1  one-cycle RAM read enable.
- ram_q  in  8  RAM B-port data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an upload session ends.
- overrun  out  1  sticky: a read strobe was dropped; cleared at session start.

Behaviour:
- Reset values: all outputs 0, ioctl_din = 8'h00, state = IDLE. Reset applied mid-fetch or mid-session aborts immediately; done is not pulsed.
- State IDLE:
  - Rising edge of ioctl_upload (registered compare against the previous value) -> PAUSE.
  - In the same transition: core_pause <= 1, overrun <= 0, timeout counter <= 0, checksum accumulator <= 0.
- State PAUSE:
  - Counter increments each cycle.
  - core_pause_ack = 1, or counter reaching PAUSE_TIMEOUT -> READY.
  - ioctl_rd seen here is dropped and sets overrun.
- State READY: on ioctl_rd, latch ioctl_addr and clear ioctl_din_valid.
  - If addr < SIZE: ram_addr <= addr[AW-1:0], ram_rd = 1 for exactly one cycle, -> FETCH.
  - Otherwise: ioctl_din <= FILL and ioctl_din_valid <= 1 on the next edge; stay in READY. Latency is 1 cycle.
- State FETCH:
  - Waits RAM_LAT cycles, then captures ioctl_din <= ram_q and sets ioctl_din_valid <= 1.
  - Adds ram_q into the checksum accumulator (8-bit, wrap-around), then -> READY.
  - Latency from ioctl_rd to ioctl_din_valid is RAM_LAT+1 cycles.
  - ioctl_rd seen during FETCH is dropped and sets overrun; the current fetch completes unaffected.
- Hold and address rules:
  - ioctl_din holds its value until the next accepted read.
  - ram_addr holds its value between reads.
  - ioctl_addr[24:AW] nonzero counts as out of range.
- Session end:
  - ioctl_upload falling in any non-IDLE state -> IDLE on the next edge, including mid-FETCH, where the fetch is discarded.
  - On that edge: core_pause <= 0, ioctl_din_valid <= 0, and done pulses high for one cycle.
  - ioctl_rd coincident with the falling ioctl_upload is ignored.
- Session start and ack timing:
  - ioctl_upload rising while already busy is not possible; no edge is detected because the level is already high.
  - core_pause_ack is ignored outside PAUSE.

Optional Feature:
- Macro: NVRAM_UPLOAD_CHECKSUM_EN.
- Defined:
  - A read at addr == SIZE returns (0 - accumulator) mod 256 with 1-cycle latency, so all uploaded bytes plus this byte sum to 0 mod 256.
  - Addresses > SIZE return FILL.
  - Reads at or above SIZE do not modify the accumulator.
  - Re-reading an in-range address adds its byte again.
- Undefined: no accumulator logic is built; every addr >= SIZE returns FILL.

Test Plan:
- SIZE=4, RAM_LAT=1, RAM = 01,02,03,04; upload rises and ack arrives 3 cycles later.
  - Expect: core_pause=1 one cycle after the rise; READY after the ack.
  - Reads at addr 0..3 return 01,02,03,04, each with ioctl_din_valid exactly 2 cycles after ioctl_rd.
- Same setup with checksum enabled; read addr 4.
  - Expect: ioctl_din = F6 after 1 cycle.
  - Reading addr 5 returns FF.
  - Reading addr 4 after a repeat read of addr 0 returns F5.
- core_pause_ack tied low, PAUSE_TIMEOUT=255.
  - Expect: READY entered exactly 255 cycles after PAUSE entry.
  - A read issued at cycle 100 is dropped and overrun=1.
- RAM_LAT=3; second ioctl_rd issued 2 cycles after the first.
  - Expect: second strobe dropped, overrun=1, and the first data is valid at cycle 4.
  - A new session clears overrun.
- Upload falls one cycle into FETCH.
  - Expect: next edge shows state IDLE, core_pause=0, ioctl_din_valid=0, done high for 1 cycle, and the late ram_q is not captured.
- Reset asserted mid-FETCH.
  - Expect: all outputs 0 on the next edge, with no done pulse.

Source files
------------

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: services data_io upload (host read-back) byte reads
// from the core's hiscore/NVRAM B-port and returns them on ioctl_din.
// The core is paused for the whole session so the RAM contents stay stable.
// Addresses at or above SIZE return FILL.
// Optional feature: define NVRAM_UPLOAD_CHECKSUM_EN to make a read at
// addr == SIZE return the two's-complement of the running byte sum, so the
// uploaded bytes plus that byte sum to zero mod 256.
module nvram_upload_reader #(
  parameter int         AW            = 10,
  parameter int         SIZE          = 1024,
  parameter int         RAM_LAT       = 1,
  parameter int         PAUSE_TIMEOUT = 255,
  parameter logic [7:0] FILL          = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_din_valid,
  output logic          core_pause,
  input  logic          core_pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAUSE = 2'd1,
    S_READY = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  // Pause counter is wide enough to hold PAUSE_TIMEOUT; READY is entered on
  // the edge where the count reaches PAUSE_TIMEOUT.
  localparam int              TCW      = $clog2(PAUSE_TIMEOUT + 1) + 1;
  localparam logic [TCW-1:0]  TO_LAST  = TCW'(PAUSE_TIMEOUT - 1);
  localparam logic [1:0]      LAT_LAST = 2'(RAM_LAT - 1);
  localparam logic [24:0]     SIZE_A   = 25'(SIZE);

  state_t         state_q, state_d;
  logic           upload_prev_q, upload_prev_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [1:0]     lat_q, lat_d;
  logic [7:0]     din_q, din_d;
  logic           din_valid_q, din_valid_d;
  logic           pause_q, pause_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic           ram_rd_c;
  logic           upload_rise;
  logic           in_range;
  logic [7:0]     oor_byte;

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0]     acc_q, acc_d;
`endif

  assign upload_rise = ioctl_upload & ~upload_prev_q;
  // Upper address bits are part of the compare, so any nonzero bit above
  // AW lands out of range.
  assign in_range    = (ioctl_addr < SIZE_A);

  // Byte returned for an out-of-range read.
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  assign oor_byte = (ioctl_addr == SIZE_A) ? 8'(8'h00 - acc_q) : FILL;
`else
  assign oor_byte = FILL;
`endif

  // Next-state and output decode for the upload session FSM.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would infer a latch.
    state_d       = state_q;
    upload_prev_d = ioctl_upload;
    tcnt_d        = tcnt_q;
    lat_d         = lat_q;
    din_d         = din_q;
    din_valid_d   = din_valid_q;
    pause_d       = pause_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    ram_addr_d    = ram_addr_q;
    ram_rd_c      = 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    acc_d         = acc_q;
`endif

    if (state_q != S_IDLE && !ioctl_upload) begin
      // Session ended: abandon any fetch in flight, a coincident strobe is
      // ignored.
      state_d     = S_IDLE;
      pause_d     = 1'b0;
      din_valid_d = 1'b0;
      done_d      = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (upload_rise) begin
            state_d   = S_PAUSE;
            pause_d   = 1'b1;
            overrun_d = 1'b0;
            tcnt_d    = '0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            acc_d     = 8'h00;
`endif
          end
        end

        S_PAUSE: begin
          tcnt_d = tcnt_q + 1'b1;
          if (core_pause_ack || tcnt_q >= TO_LAST) begin
            state_d = S_READY;
          end
          if (ioctl_rd) begin
            overrun_d = 1'b1;
          end
        end

        S_READY: begin
          if (ioctl_rd) begin
            din_valid_d = 1'b0;
            if (in_range) begin
              // Address and enable go to the RAM in the strobe cycle itself
              // so the total latency is RAM_LAT+1.
              ram_addr_d = ioctl_addr[AW-1:0];
              ram_rd_c   = 1'b1;
              lat_d      = '0;
              state_d    = S_FETCH;
            end else begin
              din_d       = oor_byte;
              din_valid_d = 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (ioctl_rd) begin
            overrun_d = 1'b1;
          end
          if (lat_q == LAT_LAST) begin
            din_d       = ram_q;
            din_valid_d = 1'b1;
            state_d     = S_READY;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            acc_d       = acc_q + ram_q;
`endif
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      upload_prev_q <= 1'b0;
      tcnt_q        <= '0;
      lat_q         <= '0;
      din_q         <= 8'h00;
      din_valid_q   <= 1'b0;
      pause_q       <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      ram_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      upload_prev_q <= upload_prev_d;
      tcnt_q        <= tcnt_d;
      lat_q         <= lat_d;
      din_q         <= din_d;
      din_valid_q   <= din_valid_d;
      pause_q       <= pause_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      ram_addr_q    <= ram_addr_d;
    end
  end

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  // Running 8-bit sum of every byte fetched during the session.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  assign ioctl_din       = din_q;
  assign ioctl_din_valid = din_valid_q;
  assign core_pause      = pause_q;
  assign ram_addr        = ram_addr_d;
  assign ram_rd          = ram_rd_c & ~reset;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign overrun         = overrun_q;

endmodule
